// File: rtl/evg_event_arbiter.sv
// ---------------------------------------------------------------------------
// evg_event_arbiter
//
// Merges three fire-and-forget event-request streams (sequencer A,
// sequencer B, trigger/software) into one AXI-Stream-style event stream for
// the EVG transmitter.
//
// Each source has a small FIFO. Sources cannot be stalled, so an event that
// arrives at a full FIFO with no pop that cycle is dropped. Each drop
// increments a saturating per-source counter and sets a sticky flag.
//
// The output register pops the highest-priority non-empty FIFO whenever it
// is free to advance. Priority is seqA > seqB > trig. The output register
// only ever loads from FIFO contents, never straight from a source.
//
// Ports
//   evgTxClk, evgTxReset        clock, asynchronous active-high reset
//   evgSeqAEventTDATA/TVALID    sequencer A request (code 0 = null)
//   evgSeqBEventTDATA/TVALID    sequencer B request
//   evgTrigEventTDATA/TVALID    trigger / software request
//   evgEventTDATA/TVALID/TREADY merged output to the transmitter
//   clearDropCounters           strobe: zero drop counters and sticky flags
//   dropCounts                  {trig, seqB, seqA} saturating drop counters
//   dropSticky                  {trig, seqB, seqA} sticky overflow flags
//   fifoOccupancy               {trig, seqB, seqA} post-edge FIFO entry counts
// ---------------------------------------------------------------------------
module evg_event_arbiter #(
    parameter int EVENTCODE_WIDTH    = 8,
    parameter int FIFO_DEPTH         = 4,
    parameter int DROP_COUNTER_WIDTH = 8
) (
    input  logic                                   evgTxClk,
    input  logic                                   evgTxReset,
    input  logic [EVENTCODE_WIDTH-1:0]             evgSeqAEventTDATA,
    input  logic                                   evgSeqAEventTVALID,
    input  logic [EVENTCODE_WIDTH-1:0]             evgSeqBEventTDATA,
    input  logic                                   evgSeqBEventTVALID,
    input  logic [EVENTCODE_WIDTH-1:0]             evgTrigEventTDATA,
    input  logic                                   evgTrigEventTVALID,
    output logic [EVENTCODE_WIDTH-1:0]             evgEventTDATA,
    output logic                                   evgEventTVALID,
    input  logic                                   evgEventTREADY,
    input  logic                                   clearDropCounters,
    output logic [3*DROP_COUNTER_WIDTH-1:0]        dropCounts,
    output logic [2:0]                             dropSticky,
    output logic [3*($clog2(FIFO_DEPTH)+1)-1:0]    fifoOccupancy
);

    localparam int NSRC  = 3;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    function automatic logic [DROP_COUNTER_WIDTH-1:0] satInc(
        input logic [DROP_COUNTER_WIDTH-1:0] value
    );
        return (&value) ? value : value + 1'b1;
    endfunction

    // Source index 0 = seqA, 1 = seqB, 2 = trig; lower index wins.
    logic [EVENTCODE_WIDTH-1:0]    srcData [NSRC];
    logic [NSRC-1:0]               srcValid;

    logic [EVENTCODE_WIDTH-1:0]    fifoMem [NSRC][FIFO_DEPTH];
    logic [PTR_W-1:0]              wrPtr   [NSRC];
    logic [PTR_W-1:0]              rdPtr   [NSRC];
    logic [CNT_W-1:0]              count   [NSRC];
    logic [DROP_COUNTER_WIDTH-1:0] dropCnt [NSRC];
    logic [NSRC-1:0]               sticky;

    logic [NSRC-1:0]               notEmpty;
    logic [NSRC-1:0]               isFull;
    logic [NSRC-1:0]               pop;
    logic [NSRC-1:0]               push;
    logic [NSRC-1:0]               drop;
    logic                          advance;
    logic [EVENTCODE_WIDTH-1:0]    selData;

    always_comb begin
        srcData[0] = evgSeqAEventTDATA;
        srcData[1] = evgSeqBEventTDATA;
        srcData[2] = evgTrigEventTDATA;
        srcValid   = {evgTrigEventTVALID, evgSeqBEventTVALID, evgSeqAEventTVALID};
    end

    assign advance = !evgEventTVALID || evgEventTREADY;

    always_comb begin
        notEmpty = '0;
        isFull   = '0;
        push     = '0;
        drop     = '0;
        for (int i = 0; i < NSRC; i++) begin
            notEmpty[i] = (count[i] != '0);
            isFull[i]   = (count[i] == FULL_CNT);
        end
        // Fixed priority: a lower-priority FIFO pops only when all higher ones are empty.
        pop[0] = advance && notEmpty[0];
        pop[1] = advance && !notEmpty[0] && notEmpty[1];
        pop[2] = advance && !notEmpty[0] && !notEmpty[1] && notEmpty[2];
        // A full FIFO still takes the write when its head leaves on the same edge.
        for (int i = 0; i < NSRC; i++) begin
            if (srcValid[i] && (srcData[i] != '0)) begin
                push[i] = !isFull[i] || pop[i];
                drop[i] = isFull[i] && !pop[i];
            end
        end
    end

    always_comb begin
        selData = fifoMem[2][rdPtr[2]];
        if (notEmpty[1]) selData = fifoMem[1][rdPtr[1]];
        if (notEmpty[0]) selData = fifoMem[0][rdPtr[0]];
    end

    // Storage needs no reset: the pointers and counts define what is valid.
    always_ff @(posedge evgTxClk) begin
        for (int i = 0; i < NSRC; i++) begin
            if (push[i]) fifoMem[i][wrPtr[i]] <= srcData[i];
        end
    end

    // FIFO bookkeeping and drop accounting.
    always_ff @(posedge evgTxClk or posedge evgTxReset) begin
        if (evgTxReset) begin
            for (int i = 0; i < NSRC; i++) begin
                wrPtr[i]   <= '0;
                rdPtr[i]   <= '0;
                count[i]   <= '0;
                dropCnt[i] <= '0;
            end
            sticky <= '0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (push[i]) wrPtr[i] <= wrPtr[i] + 1'b1;
                if (pop[i])  rdPtr[i] <= rdPtr[i] + 1'b1;
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
                // Clear takes precedence over a coinciding drop.
                if (clearDropCounters) begin
                    dropCnt[i] <= '0;
                    sticky[i]  <= 1'b0;
                end else if (drop[i]) begin
                    dropCnt[i] <= satInc(dropCnt[i]);
                    sticky[i]  <= 1'b1;
                end
            end
        end
    end

    // Output register stage: loads only from FIFO heads, holds while stalled.
    always_ff @(posedge evgTxClk or posedge evgTxReset) begin
        if (evgTxReset) begin
            evgEventTVALID <= 1'b0;
            evgEventTDATA  <= '0;
        end else if (advance) begin
            if (|notEmpty) begin
                evgEventTVALID <= 1'b1;
                evgEventTDATA  <= selData;
            end else begin
                evgEventTVALID <= 1'b0;
            end
        end
    end

    assign dropCounts    = {dropCnt[2], dropCnt[1], dropCnt[0]};
    assign dropSticky    = sticky;
    assign fifoOccupancy = {count[2], count[1], count[0]};

endmodule

// File: tb/tb_evg_event_arbiter.sv
module tb_evg_event_arbiter;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [W-1:0] da, db, dt;
    logic        va, vb, vt;
    logic [W-1:0] oData;
    logic        oValid;
    logic        rdy;
    logic        clr;
    logic [3*DW-1:0] drops;
    logic [2:0]  stk;
    logic [8:0]  occ;

    int nVec  = 0;
    int nFail = 0;

    always #5 clk = ~clk;

    evg_event_arbiter #(
        .EVENTCODE_WIDTH(W),
        .FIFO_DEPTH(D),
        .DROP_COUNTER_WIDTH(DW)
    ) dut (
        .evgTxClk(clk),
        .evgTxReset(rst),
        .evgSeqAEventTDATA(da),
        .evgSeqAEventTVALID(va),
        .evgSeqBEventTDATA(db),
        .evgSeqBEventTVALID(vb),
        .evgTrigEventTDATA(dt),
        .evgTrigEventTVALID(vt),
        .evgEventTDATA(oData),
        .evgEventTVALID(oValid),
        .evgEventTREADY(rdy),
        .clearDropCounters(clr),
        .dropCounts(drops),
        .dropSticky(stk),
        .fifoOccupancy(occ)
    );

    typedef struct {
        logic         va; logic [7:0] da;
        logic         vb; logic [7:0] db;
        logic         vt; logic [7:0] dt;
        logic         rdy;
        logic         clr;
        logic         eV;
        logic [7:0]   eD;
        logic [8:0]   eOcc;
        logic [23:0]  eDrop;
        logic [2:0]   eStk;
    } vec_t;

    vec_t tbl [22];

    // Reference model state: one queue per source plus the output slot.
    logic [7:0] mq [3][$];
    logic       mV;
    logic [7:0] mD;
    int         mDrop [3];
    logic [2:0] mStk;

    function automatic logic [8:0] occOf(input int a, input int b, input int t);
        logic [8:0] r;
        r = {t[2:0], b[2:0], a[2:0]};
        return r;
    endfunction

    function automatic vec_t mk(
        input logic iva, input logic [7:0] ida,
        input logic ivb, input logic [7:0] idb,
        input logic ivt, input logic [7:0] idt,
        input logic irdy, input logic iclr,
        input logic eV, input logic [7:0] eD,
        input logic [8:0] eOcc, input logic [23:0] eDrop, input logic [2:0] eStk);
        vec_t v;
        v.va = iva; v.da = ida; v.vb = ivb; v.db = idb; v.vt = ivt; v.dt = idt;
        v.rdy = irdy; v.clr = iclr;
        v.eV = eV; v.eD = eD; v.eOcc = eOcc; v.eDrop = eDrop; v.eStk = eStk;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIn(input logic iva, input logic [7:0] ida,
                         input logic ivb, input logic [7:0] idb,
                         input logic ivt, input logic [7:0] idt,
                         input logic irdy, input logic iclr);
        va = iva; da = ida; vb = ivb; db = idb; vt = ivt; dt = idt;
        rdy = irdy; clr = iclr;
    endtask

    task automatic modelReset();
        for (int s = 0; s < 3; s++) begin
            mq[s].delete();
            mDrop[s] = 0;
        end
        mV = 1'b0;
        mD = 8'h00;
        mStk = 3'b000;
    endtask

    // One clock edge of the arbiter, from the rules: pick from pre-edge
    // queue contents, then enqueue arrivals into whatever room is left.
    task automatic modelStep();
        logic       inV [3];
        logic [7:0] inD [3];
        bit         found;
        inV[0] = va; inV[1] = vb; inV[2] = vt;
        inD[0] = da; inD[1] = db; inD[2] = dt;
        if (!mV || rdy) begin
            found = 0;
            for (int s = 0; s < 3; s++) begin
                if (!found && mq[s].size() > 0) begin
                    mD = mq[s].pop_front();
                    found = 1;
                end
            end
            mV = found;
        end
        for (int s = 0; s < 3; s++) begin
            if (inV[s] && inD[s] != 8'h00) begin
                if (mq[s].size() < D) begin
                    mq[s].push_back(inD[s]);
                end else begin
                    if (mDrop[s] < 255) mDrop[s]++;
                    mStk[s] = 1'b1;
                end
            end
            if (clr) begin
                mDrop[s] = 0;
                mStk[s]  = 1'b0;
            end
        end
    endtask

    task automatic checkModel(input int cyc);
        logic [23:0] eDrop;
        eDrop = {mDrop[2][7:0], mDrop[1][7:0], mDrop[0][7:0]};
        chk($sformatf("rnd%0d tvalid", cyc), 32'(oValid), 32'(mV));
        chk($sformatf("rnd%0d tdata", cyc), 32'(oData), 32'(mD));
        chk($sformatf("rnd%0d occupancy", cyc), 32'(occ),
            32'(occOf(mq[0].size(), mq[1].size(), mq[2].size())));
        chk($sformatf("rnd%0d dropCounts", cyc), 32'(drops), 32'(eDrop));
        chk($sformatf("rnd%0d sticky", cyc), 32'(stk), 32'(mStk));
    endtask

    initial begin
        rst = 1'b1;
        setIn(0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 0);

        // Directed sequence: single event, simultaneous requests, backpressure
        // with overflow, full-with-pop, null codes, clear.
        tbl[0]  = mk(1,8'h21, 0,8'h00, 0,8'h00, 1,0,  0,8'h00, occOf(1,0,0), 24'h0,      3'b000);
        tbl[1]  = mk(0,8'h00, 0,8'h00, 0,8'h00, 1,0,  1,8'h21, occOf(0,0,0), 24'h0,      3'b000);
        tbl[2]  = mk(0,8'h00, 0,8'h00, 0,8'h00, 1,0,  0,8'h21, occOf(0,0,0), 24'h0,      3'b000);
        tbl[3]  = mk(1,8'h10, 1,8'h20, 1,8'h30, 1,0,  0,8'h21, occOf(1,1,1), 24'h0,      3'b000);
        tbl[4]  = mk(0,8'h00, 0,8'h00, 0,8'h00, 1,0,  1,8'h10, occOf(0,1,1), 24'h0,      3'b000);
        tbl[5]  = mk(0,8'h00, 0,8'h00, 0,8'h00, 1,0,  1,8'h20, occOf(0,0,1), 24'h0,      3'b000);
        tbl[6]  = mk(0,8'h00, 0,8'h00, 0,8'h00, 1,0,  1,8'h30, occOf(0,0,0), 24'h0,      3'b000);
        tbl[7]  = mk(0,8'h00, 0,8'h00, 0,8'h00, 1,0,  0,8'h30, occOf(0,0,0), 24'h0,      3'b000);
        tbl[8]  = mk(1,8'h01, 0,8'h00, 0,8'h00, 0,0,  0,8'h30, occOf(1,0,0), 24'h0,      3'b000);
        tbl[9]  = mk(1,8'h02, 0,8'h00, 0,8'h00, 0,0,  1,8'h01, occOf(1,0,0), 24'h0,      3'b000);
        tbl[10] = mk(1,8'h03, 0,8'h00, 0,8'h00, 0,0,  1,8'h01, occOf(2,0,0), 24'h0,      3'b000);
        tbl[11] = mk(1,8'h04, 0,8'h00, 0,8'h00, 0,0,  1,8'h01, occOf(3,0,0), 24'h0,      3'b000);
        tbl[12] = mk(1,8'h05, 0,8'h00, 0,8'h00, 0,0,  1,8'h01, occOf(4,0,0), 24'h0,      3'b000);
        tbl[13] = mk(1,8'h06, 0,8'h00, 0,8'h00, 0,0,  1,8'h01, occOf(4,0,0), 24'h000001, 3'b001);
        tbl[14] = mk(1,8'h55, 0,8'h00, 0,8'h00, 1,0,  1,8'h02, occOf(4,0,0), 24'h000001, 3'b001);
        tbl[15] = mk(0,8'h00, 0,8'h00, 0,8'h00, 1,0,  1,8'h03, occOf(3,0,0), 24'h000001, 3'b001);
        tbl[16] = mk(0,8'h00, 0,8'h00, 0,8'h00, 1,0,  1,8'h04, occOf(2,0,0), 24'h000001, 3'b001);
        tbl[17] = mk(0,8'h00, 0,8'h00, 0,8'h00, 1,0,  1,8'h05, occOf(1,0,0), 24'h000001, 3'b001);
        tbl[18] = mk(0,8'h00, 0,8'h00, 0,8'h00, 1,0,  1,8'h55, occOf(0,0,0), 24'h000001, 3'b001);
        tbl[19] = mk(0,8'h00, 0,8'h00, 0,8'h00, 1,0,  0,8'h55, occOf(0,0,0), 24'h000001, 3'b001);
        tbl[20] = mk(1,8'h00, 1,8'h00, 1,8'h00, 1,0,  0,8'h55, occOf(0,0,0), 24'h000001, 3'b001);
        tbl[21] = mk(0,8'h00, 0,8'h00, 0,8'h00, 1,1,  0,8'h55, occOf(0,0,0), 24'h0,      3'b000);

        repeat (2) tick();
        chk("inreset tvalid", 32'(oValid), 32'h0);
        chk("inreset occupancy", 32'(occ), 32'h0);
        rst = 1'b0;
        tick();
        chk("reset tvalid", 32'(oValid), 32'h0);
        chk("reset tdata", 32'(oData), 32'h0);
        chk("reset occupancy", 32'(occ), 32'h0);
        chk("reset dropCounts", 32'(drops), 32'h0);
        chk("reset sticky", 32'(stk), 32'h0);

        for (int i = 0; i < 22; i++) begin
            setIn(tbl[i].va, tbl[i].da, tbl[i].vb, tbl[i].db,
                  tbl[i].vt, tbl[i].dt, tbl[i].rdy, tbl[i].clr);
            tick();
            chk($sformatf("vec%0d tvalid", i), 32'(oValid), 32'(tbl[i].eV));
            chk($sformatf("vec%0d tdata", i), 32'(oData), 32'(tbl[i].eD));
            chk($sformatf("vec%0d occupancy", i), 32'(occ), 32'(tbl[i].eOcc));
            chk($sformatf("vec%0d dropCounts", i), 32'(drops), 32'(tbl[i].eDrop));
            chk($sformatf("vec%0d sticky", i), 32'(stk), 32'(tbl[i].eStk));
        end

        // Saturation: fill seqA under backpressure, then 300 overflowing events.
        for (int k = 1; k <= 5; k++) begin
            setIn(1, 8'(8'h40 + k), 0, 8'h00, 0, 8'h00, 0, 0);
            tick();
        end
        for (int k = 0; k < 300; k++) begin
            setIn(1, 8'h77, 0, 8'h00, 0, 8'h00, 0, 0);
            tick();
        end
        chk("sat dropA", 32'(drops[7:0]), 32'hFF);
        chk("sat dropB", 32'(drops[15:8]), 32'h00);
        chk("sat sticky", 32'(stk), 32'h1);
        chk("sat occupancy", 32'(occ), 32'(occOf(4,0,0)));
        chk("sat held tdata", 32'(oData), 32'h41);
        chk("sat held tvalid", 32'(oValid), 32'h1);

        // Clear coinciding with a drop: clear wins.
        setIn(1, 8'h77, 0, 8'h00, 0, 8'h00, 0, 1);
        tick();
        chk("clr+drop dropCounts", 32'(drops), 32'h0);
        chk("clr+drop sticky", 32'(stk), 32'h0);
        setIn(1, 8'h78, 0, 8'h00, 0, 8'h00, 0, 0);
        tick();
        chk("post-clr dropA", 32'(drops), 32'h1);
        chk("post-clr sticky", 32'(stk), 32'h1);

        // Asynchronous reset between edges with events queued and TVALID high.
        setIn(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("async tvalid", 32'(oValid), 32'h0);
        chk("async tdata", 32'(oData), 32'h0);
        chk("async occupancy", 32'(occ), 32'h0);
        chk("async dropCounts", 32'(drops), 32'h0);
        chk("async sticky", 32'(stk), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("postrst%0d tvalid", k), 32'(oValid), 32'h0);
            chk($sformatf("postrst%0d occupancy", k), 32'(occ), 32'h0);
        end

        // Randomized traffic against the queue model.
        modelReset();
        for (int c = 0; c < 3000; c++) begin
            int phase;
            int rdyPct;
            phase  = (c / 250) % 3;
            rdyPct = (phase == 0) ? 90 : (phase == 1) ? 30 : 60;
            va  = ($urandom_range(0, 99) < 45);
            vb  = ($urandom_range(0, 99) < 40);
            vt  = ($urandom_range(0, 99) < 35);
            da  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            db  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            dt  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            rdy = ($urandom_range(0, 99) < rdyPct);
            clr = ($urandom_range(0, 99) == 0);
            modelStep();
            tick();
            checkModel(c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
